arch_state_checker: RTL
=======================

Name: arch_state_checker

Overview:
- Synthesizable end-of-program checker for the pipelined RISC-V CPU test environment; sits beside the CPU and instruction/data memories.
- Counts run cycles and detects program halt or timeout.
- After halt, waits a fixed drain period for the pipeline, then compares every architectural register and a data-memory window against a golden image, one word per cycle.
- Reports error count, first mismatch location and a pass/fail verdict.

Parameters:
XLEN, 32, register/memory word width
NUM_REGS, 32, registers compared (indices 0..NUM_REGS-1)
MEM_BASE, 0, first data-memory word address compared
MEM_WORDS, 16, memory words compared; 0 skips the memory phase
DRAIN_CYCLES, 8, cycles waited after halt before comparing
MAX_CYCLES, 1000, run-cycle budget before timeout
GOLD_AW, 12, golden image word-address width
ERR_W, 16, error counter width (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
halt_i  in  1  program finished (fetch left program image); level or pulse
reg_raddr_o  out  5  register-file debug read address
reg_rdata_i  in  XLEN  register data; valid 1 cycle after address
mem_raddr_o  out  16  data-memory debug word address
mem_rdata_i  in  XLEN  memory data; valid 1 cycle after address
gold_raddr_o  out  GOLD_AW  golden ROM word address
gold_rdata_i  in  XLEN  golden data; valid 1 cycle after address
mismatch_o  out  1  one-cycle strobe per failed compare
busy_o  out  1  high in DRAIN/REG_CMP/MEM_CMP
done_o  out  1  verdict valid; held until reset
pass_o  out  1  done and no errors and no timeout
timeout_o  out  1  MAX_CYCLES reached without halt
err_count_o  out  ERR_W  mismatches counted
first_err_idx_o  out  GOLD_AW  golden index of first mismatch; all-ones if none
cycle_count_o  out  32  run cycles elapsed at halt/timeout

Behaviour:
- Reset (rst==0 at posedge clk): state RUN; all counters 0; mismatch_o, busy_o, done_o, pass_o, timeout_o = 0; err_count_o = 0; first_err_idx_o = all-ones; all read addresses 0. Reset at any state, including mid-compare, aborts and restarts in RUN.
- RUN: cycle_count increments each cycle. If halt_i: go to DRAIN, freeze cycle_count. Else if cycle_count == MAX_CYCLES-1: timeout_o=1, go to DONE (no compare). halt wins over timeout when both occur in the same cycle.
- DRAIN: counter 0..DRAIN_CYCLES-1; halt_i ignored; then REG_CMP. DRAIN_CYCLES=0 goes straight to REG_CMP.
- REG_CMP: issue index i=0..NUM_REGS-1, one per cycle: reg_raddr_o=i, gold_raddr_o=i. Compare stage one cycle later: if reg_rdata_i != gold_rdata_i, pulse mismatch_o, increment err_count (saturate at 2^ERR_W-1), and latch first_err_idx if still all-ones.
- MEM_CMP: issue j=0..MEM_WORDS-1: mem_raddr_o=MEM_BASE+j (16-bit wrap), gold_raddr_o=NUM_REGS+j; compare as above. Skipped when MEM_WORDS=0.
- Compare pipeline: issue and compare overlap, so throughput is 1 word/cycle. The last compare completes one cycle after the final issue. The REG-to-MEM transition causes no bubble.
- DONE: entered one cycle after the last compare. done_o=1; pass_o = (err_count==0) && !timeout_o. Block stays in DONE with outputs stable until reset.
- Latency from halt to done_o: DRAIN_CYCLES + NUM_REGS + MEM_WORDS + 1 cycles.
- No X detection in RTL; halt is generated externally.

Decomposition:
- Shared package chk_pkg: FSM state enum (RUN, DRAIN, REG_CMP, MEM_CMP, DONE) and the all-ones "no error" index constant.
- One sub-module, chk_compare_stage: 1-cycle-delayed compare with valid, index pipeline, saturating error counter and first-error latch.
- Top level holds the FSM, cycle counter, drain counter and address generation.

Test Plan:
- Clean run: halt at cycle 120; all regs and memory match golden; defaults -> done_o exactly 8+32+16+1=57 cycles after halt, pass_o=1, err_count_o=0, first_err_idx_o=0xFFF, cycle_count_o=120.
- Register mismatch: reg 5 and reg 31 differ from golden -> two mismatch_o pulses, err_count_o=2, first_err_idx_o=5, pass_o=0.
- Memory mismatch: MEM_BASE=0x40, word 3 differs -> mem_raddr_o sequence 0x40..0x4F, err_count_o=1, first_err_idx_o=35, pass_o=0.
- Timeout: halt never asserted, MAX_CYCLES=1000 -> timeout_o=1 and done_o=1 after 1000 run cycles, no compare addresses issued, pass_o=0.
- Reset mid-compare: rst low during REG_CMP index 10 -> next cycle in RUN, all outputs at reset values; rerun passes.
- Edge cases: MEM_WORDS=0 and DRAIN_CYCLES=0 -> done_o exactly 33 cycles after halt. Error saturation: ERR_W=2 with 5 mismatches -> err_count_o=3.

Source files
------------

// File: rtl/chk_pkg.sv
// ---------------------------------------------------------------------------
// chk_pkg
// Shared definitions for the end-of-program architectural state checker.
//   chk_state_e      : checker FSM states
//   NO_ERR_IDX_WIDE  : all-ones "no mismatch seen" index; modules slice it
//                      down to their golden-index width
//   CHK_STATE_W      : width of the exported debug state
// ---------------------------------------------------------------------------
package chk_pkg;

  localparam int CHK_STATE_W = 3;

  typedef enum logic [CHK_STATE_W-1:0] {
    ST_RUN     = 3'd0,  // program executing, run cycles counted
    ST_DRAIN   = 3'd1,  // halt seen, waiting for the pipeline to retire
    ST_REG_CMP = 3'd2,  // streaming register file against golden image
    ST_MEM_CMP = 3'd3,  // streaming data-memory window against golden image
    ST_DONE    = 3'd4   // verdict valid, held until reset
  } chk_state_e;

  localparam logic [31:0] NO_ERR_IDX_WIDE = 32'hFFFF_FFFF;

endpackage

// File: rtl/chk_compare_stage.sv
// ---------------------------------------------------------------------------
// chk_compare_stage
// One-cycle-delayed comparator. An issue in cycle N drives read addresses to
// the register file / data memory / golden ROM, whose synchronous read data
// arrive in cycle N+1. This stage remembers what was issued, compares in
// cycle N+1 and registers the result at the end of N+1.
//
// Issue/compare handshake: issue_valid is a single-cycle qualifier with no
// back-pressure (there is no ready); every cycle with issue_valid=1 produces
// exactly one compare one cycle later, and issue_is_mem / issue_idx are
// only meaningful while issue_valid=1.
//
// Ports
//   clk, rst            : clock, synchronous active-low reset
//   issue_valid         : an address was issued this cycle
//   issue_is_mem        : issued word comes from data memory (else reg file)
//   issue_idx           : golden index of the issued word
//   reg_rdata/mem_rdata : read data, valid one cycle after issue
//   gold_rdata          : golden data, valid one cycle after issue
//   mismatch            : one-cycle strobe per failed compare
//   err_count           : saturating mismatch count
//   first_err_idx       : golden index of first mismatch, all-ones if none
// ---------------------------------------------------------------------------
module chk_compare_stage
  import chk_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int GOLD_AW = 12,
  parameter int ERR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic               issue_is_mem,
  input  logic [GOLD_AW-1:0] issue_idx,
  input  logic [XLEN-1:0]    reg_rdata,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic [XLEN-1:0]    gold_rdata,
  output logic               mismatch,
  output logic [ERR_W-1:0]   err_count,
  output logic [GOLD_AW-1:0] first_err_idx
);

  localparam logic [GOLD_AW-1:0] NO_ERR_IDX = NO_ERR_IDX_WIDE[GOLD_AW-1:0];
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

  // Issue-side bookkeeping delayed to line up with the returning read data.
  logic               cmp_valid_q;
  logic               cmp_is_mem_q;
  logic [GOLD_AW-1:0] cmp_idx_q;

  logic               mismatch_q;
  logic [ERR_W-1:0]   err_count_q;
  logic [GOLD_AW-1:0] first_err_idx_q;

  logic [XLEN-1:0]    actual;
  logic               miss;

  always_comb begin
    actual = reg_rdata;
    if (cmp_is_mem_q) begin
      actual = mem_rdata;
    end
    miss = cmp_valid_q && (actual != gold_rdata);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmp_valid_q     <= 1'b0;
      cmp_is_mem_q    <= 1'b0;
      cmp_idx_q       <= '0;
      mismatch_q      <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= NO_ERR_IDX;
    end else begin
      cmp_valid_q  <= issue_valid;
      cmp_is_mem_q <= issue_is_mem;
      cmp_idx_q    <= issue_idx;
      mismatch_q   <= miss;
      if (miss && (err_count_q != ERR_MAX)) begin
        err_count_q <= err_count_q + 1'b1;
      end
      // Only the very first failure is recorded; later ones leave it alone.
      if (miss && (first_err_idx_q == NO_ERR_IDX)) begin
        first_err_idx_q <= cmp_idx_q;
      end
    end
  end

  assign mismatch      = mismatch_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: rtl/arch_state_checker.sv
// ---------------------------------------------------------------------------
// arch_state_checker
// End-of-program checker for the pipelined RISC-V test environment. Counts
// run cycles until halt or timeout, lets the pipeline drain, then streams the
// register file and a data-memory window against a golden image at one word
// per cycle and reports a verdict.
//
// Ports
//   clk, rst         : clock, synchronous active-low reset
//   halt_i           : program finished (level or pulse, only seen in RUN)
//   reg_raddr_o      : register-file debug read address (data 1 cycle later)
//   reg_rdata_i      : register-file debug read data
//   mem_raddr_o      : data-memory debug word address (data 1 cycle later)
//   mem_rdata_i      : data-memory debug read data
//   gold_raddr_o     : golden ROM word address (data 1 cycle later)
//   gold_rdata_i     : golden ROM data
//   mismatch_o       : one-cycle strobe per failed compare
//   busy_o           : draining or comparing
//   done_o           : verdict valid, held until reset
//   pass_o           : done, no mismatches and no timeout
//   timeout_o        : run budget exhausted without halt
//   err_count_o      : saturating mismatch count
//   first_err_idx_o  : golden index of first mismatch, all-ones if none
//   cycle_count_o    : run cycles elapsed at halt / timeout
//   dbg_state_o      : current FSM state (chk_state_e encoding)
// ---------------------------------------------------------------------------
module arch_state_checker
  import chk_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int MEM_BASE     = 0,
  parameter int MEM_WORDS    = 16,
  parameter int DRAIN_CYCLES = 8,
  parameter int MAX_CYCLES   = 1000,
  parameter int GOLD_AW      = 12,
  parameter int ERR_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt_i,
  output logic [4:0]             reg_raddr_o,
  input  logic [XLEN-1:0]        reg_rdata_i,
  output logic [15:0]            mem_raddr_o,
  input  logic [XLEN-1:0]        mem_rdata_i,
  output logic [GOLD_AW-1:0]     gold_raddr_o,
  input  logic [XLEN-1:0]        gold_rdata_i,
  output logic                   mismatch_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [ERR_W-1:0]       err_count_o,
  output logic [GOLD_AW-1:0]     first_err_idx_o,
  output logic [31:0]            cycle_count_o,
  output logic [CHK_STATE_W-1:0] dbg_state_o
);

  localparam int IDX_W = 17;

  localparam logic [31:0]      MAX_LAST   = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] REG_LAST   = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] REG_END    = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] MEM_END    = IDX_W'(MEM_WORDS);
  localparam logic [15:0]      MEM_BASE16 = 16'(MEM_BASE);
  localparam bit               HAS_DRAIN  = (DRAIN_CYCLES > 0);
  localparam bit               HAS_MEM    = (MEM_WORDS > 0);

  chk_state_e       state_q, state_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      drain_q, drain_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             timeout_q, timeout_d;

  logic             reg_issue;
  logic             mem_issue;
  logic [IDX_W-1:0] gold_mem_idx;

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cycle_q   <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      drain_q   <= drain_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // The compare index runs one step past the last word of the final phase:
  // that extra cycle issues nothing and only lets the last compare retire,
  // so DONE is entered with the error count already final.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_RUN: begin
        // Halt is checked first so it wins over a same-cycle timeout.
        if (halt_i) begin
          drain_d = '0;
          idx_d   = '0;
          state_d = HAS_DRAIN ? ST_DRAIN : ST_REG_CMP;
        end else begin
          cycle_d = cycle_q + 32'd1;
          if (cycle_q == MAX_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          idx_d   = '0;
          state_d = ST_REG_CMP;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end

      ST_REG_CMP: begin
        if (idx_q == REG_END) begin
          state_d = ST_DONE;
        end else if (idx_q == REG_LAST) begin
          // Straight into the memory phase keeps the stream gap-free.
          if (HAS_MEM) begin
            idx_d   = '0;
            state_d = ST_MEM_CMP;
          end else begin
            idx_d = REG_END;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_MEM_CMP: begin
        if (idx_q == MEM_END) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Address generation: addresses are zero whenever nothing is issued.
  // -------------------------------------------------------------------------
  assign reg_issue    = (state_q == ST_REG_CMP) && (idx_q < REG_END);
  assign mem_issue    = (state_q == ST_MEM_CMP) && (idx_q < MEM_END);
  assign gold_mem_idx = REG_END + idx_q;

  always_comb begin
    reg_raddr_o  = '0;
    mem_raddr_o  = '0;
    gold_raddr_o = '0;
    if (reg_issue) begin
      reg_raddr_o  = idx_q[4:0];
      gold_raddr_o = GOLD_AW'(idx_q);
    end else if (mem_issue) begin
      // 16-bit wrap of the data-memory window is intentional.
      mem_raddr_o  = MEM_BASE16 + idx_q[15:0];
      gold_raddr_o = GOLD_AW'(gold_mem_idx);
    end
  end

  // -------------------------------------------------------------------------
  // Compare pipeline
  // -------------------------------------------------------------------------
  chk_compare_stage #(
    .XLEN    (XLEN),
    .GOLD_AW (GOLD_AW),
    .ERR_W   (ERR_W)
  ) u_compare (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (reg_issue || mem_issue),
    .issue_is_mem  (mem_issue),
    .issue_idx     (gold_raddr_o),
    .reg_rdata     (reg_rdata_i),
    .mem_rdata     (mem_rdata_i),
    .gold_rdata    (gold_rdata_i),
    .mismatch      (mismatch_o),
    .err_count     (err_count_o),
    .first_err_idx (first_err_idx_o)
  );

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  assign busy_o        = (state_q == ST_DRAIN) || (state_q == ST_REG_CMP) ||
                         (state_q == ST_MEM_CMP);
  assign done_o        = (state_q == ST_DONE);
  assign timeout_o     = timeout_q;
  assign pass_o        = done_o && (err_count_o == '0) && !timeout_q;
  assign cycle_count_o = cycle_q;
  assign dbg_state_o   = state_q;

endmodule
